// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter stage: the run-control state encoding,
// the instruction width in bytes and the default reset address.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_BITS  = $clog2(INSTR_BYTES);

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit counter with synchronous active-low reset, synchronous clear and an
// increment that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= 32'd0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the single-cycle CPU: holds the PC, commits the
// datapath's next address and provides run control. Optional retire-limit
// watchdog is built when PC_SEQUENCER_WATCHDOG_EN is defined.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] END_ADDR = 32'h0000_03FC
`ifdef PC_SEQUENCER_WATCHDOG_EN
    ,
    parameter logic [31:0] MAX_INSTR = 32'd1024
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] Next_Addr,
    output logic [31:0] PC_Addr,
    output logic        cpu_en,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired_count
`ifdef PC_SEQUENCER_WATCHDOG_EN
    ,
    output logic        watchdog_hit
`endif
);

    state_t      state;
    state_t      next_state;
    logic [31:0] next_pc;
    logic        count_en;
    logic        count_clear;
    logic        misaligned;

    assign misaligned = |Next_Addr[ALIGN_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            PC_Addr <= RESET_PC;
        end else begin
            state   <= next_state;
            PC_Addr <= next_pc;
        end
    end

`ifdef PC_SEQUENCER_WATCHDOG_EN
    logic next_wd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watchdog_hit <= 1'b0;
        end else begin
            watchdog_hit <= next_wd;
        end
    end
`endif

    // start wins over everything except reset; stall then shields all halt checks
    always_comb begin
        next_state  = state;
        next_pc     = PC_Addr;
        count_en    = 1'b0;
        count_clear = 1'b0;
`ifdef PC_SEQUENCER_WATCHDOG_EN
        next_wd     = watchdog_hit;
`endif
        if (start) begin
            next_state  = RUN;
            next_pc     = RESET_PC;
            count_clear = 1'b1;
`ifdef PC_SEQUENCER_WATCHDOG_EN
            next_wd     = 1'b0;
`endif
        end else if (state == RUN && !stall) begin
            if (misaligned) begin
                next_state = FAULT;
            end else if (Next_Addr == PC_Addr) begin
                next_state = HALT;
                count_en   = 1'b1;
            end else if (Next_Addr > END_ADDR) begin
                next_state = HALT;
                count_en   = 1'b1;
            end else begin
                next_pc  = Next_Addr;
                count_en = 1'b1;
            end
`ifdef PC_SEQUENCER_WATCHDOG_EN
            if (count_en && (({1'b0, retired_count} + 33'd1) == {1'b0, MAX_INSTR})) begin
                next_state = HALT;
                next_wd    = 1'b1;
            end
`endif
        end
    end

    assign cpu_en  = (state == RUN) && !stall && !misaligned;
    assign running = (state == RUN);
    assign halted  = (state == HALT);
    assign fault   = (state == FAULT);

    sat_counter32 u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (count_clear),
        .en    (count_en),
        .count (retired_count)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; a second instance with a small
// retire limit exercises the watchdog when PC_SEQUENCER_WATCHDOG_EN is defined.
module tb_pc_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_RUN   = 3'b001;
    localparam logic [2:0] ST_HALT  = 3'b010;
    localparam logic [2:0] ST_FAULT = 3'b100;

    typedef struct {
        logic        start;
        logic        stall;
        logic [31:0] next_addr;
        logic        exp_en;
        logic [31:0] exp_pc;
        logic [31:0] exp_count;
        logic [2:0]  exp_status;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [31:0] next_addr;
    logic [31:0] pc_addr;
    logic        cpu_en;
    logic        running;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[24];

    always #5 clk = ~clk;

`ifdef PC_SEQUENCER_WATCHDOG_EN
    logic        wd_hit_main;
    logic [31:0] wd_pc;
    logic        wd_cpu_en;
    logic        wd_running;
    logic        wd_halted;
    logic        wd_fault;
    logic [31:0] wd_count;
    logic        wd_hit;
`endif

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .Next_Addr     (next_addr),
        .PC_Addr       (pc_addr),
        .cpu_en        (cpu_en),
        .running       (running),
        .halted        (halted),
        .fault         (fault),
        .retired_count (retired_count)
`ifdef PC_SEQUENCER_WATCHDOG_EN
        ,
        .watchdog_hit  (wd_hit_main)
`endif
    );

`ifdef PC_SEQUENCER_WATCHDOG_EN
    pc_sequencer #(.MAX_INSTR(32'd4)) dut_wd (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .Next_Addr     (next_addr),
        .PC_Addr       (wd_pc),
        .cpu_en        (wd_cpu_en),
        .running       (wd_running),
        .halted        (wd_halted),
        .fault         (wd_fault),
        .retired_count (wd_count),
        .watchdog_hit  (wd_hit)
    );
`endif

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic s, input logic st, input logic [31:0] na);
        start     = s;
        stall     = st;
        next_addr = na;
        @(posedge clk);
        #1;
    endtask

    // cpu_en is judged on the inputs before the edge, state after it
    task automatic apply_stimulus(input int idx);
        string tag;
        tag       = $sformatf("vec%0d", idx);
        start     = vecs[idx].start;
        stall     = vecs[idx].stall;
        next_addr = vecs[idx].next_addr;
        #1;
        check_output({tag, " cpu_en"}, {31'd0, cpu_en}, {31'd0, vecs[idx].exp_en});
        @(posedge clk);
        #1;
        check_output({tag, " pc"}, pc_addr, vecs[idx].exp_pc);
        check_output({tag, " count"}, retired_count, vecs[idx].exp_count);
        check_output({tag, " status"}, {29'd0, fault, halted, running}, {29'd0, vecs[idx].exp_status});
    endtask

    initial begin
        //            start stall next        en    pc          count  status
        vecs[0]  = '{1'b1, 1'b0, 32'h0000, 1'b0, 32'h0000, 32'd0, ST_RUN};
        vecs[1]  = '{1'b0, 1'b0, 32'h0004, 1'b1, 32'h0004, 32'd1, ST_RUN};
        vecs[2]  = '{1'b0, 1'b0, 32'h0008, 1'b1, 32'h0008, 32'd2, ST_RUN};
        vecs[3]  = '{1'b0, 1'b0, 32'h000C, 1'b1, 32'h000C, 32'd3, ST_RUN};
        vecs[4]  = '{1'b0, 1'b0, 32'h0010, 1'b1, 32'h0010, 32'd4, ST_RUN};
        vecs[5]  = '{1'b0, 1'b0, 32'h0014, 1'b1, 32'h0014, 32'd5, ST_RUN};
        vecs[6]  = '{1'b0, 1'b1, 32'h0018, 1'b0, 32'h0014, 32'd5, ST_RUN};
        vecs[7]  = '{1'b0, 1'b1, 32'h0018, 1'b0, 32'h0014, 32'd5, ST_RUN};
        vecs[8]  = '{1'b0, 1'b1, 32'h001E, 1'b0, 32'h0014, 32'd5, ST_RUN};
        vecs[9]  = '{1'b0, 1'b0, 32'h0018, 1'b1, 32'h0018, 32'd6, ST_RUN};
        vecs[10] = '{1'b0, 1'b0, 32'h0020, 1'b1, 32'h0020, 32'd7, ST_RUN};
        vecs[11] = '{1'b0, 1'b0, 32'h0020, 1'b1, 32'h0020, 32'd8, ST_HALT};
        vecs[12] = '{1'b0, 1'b0, 32'h0024, 1'b0, 32'h0020, 32'd8, ST_HALT};
        vecs[13] = '{1'b1, 1'b0, 32'h0024, 1'b0, 32'h0000, 32'd0, ST_RUN};
        vecs[14] = '{1'b0, 1'b0, 32'h03FC, 1'b1, 32'h03FC, 32'd1, ST_RUN};
        vecs[15] = '{1'b0, 1'b0, 32'h0400, 1'b1, 32'h03FC, 32'd2, ST_HALT};
        vecs[16] = '{1'b1, 1'b0, 32'h0004, 1'b0, 32'h0000, 32'd0, ST_RUN};
        vecs[17] = '{1'b0, 1'b0, 32'h0004, 1'b1, 32'h0004, 32'd1, ST_RUN};
        vecs[18] = '{1'b0, 1'b0, 32'h001E, 1'b0, 32'h0004, 32'd1, ST_FAULT};
        vecs[19] = '{1'b0, 1'b0, 32'h0008, 1'b0, 32'h0004, 32'd1, ST_FAULT};
        vecs[20] = '{1'b1, 1'b0, 32'h0008, 1'b0, 32'h0000, 32'd0, ST_RUN};
        vecs[21] = '{1'b0, 1'b0, 32'h0004, 1'b1, 32'h0004, 32'd1, ST_RUN};
        vecs[22] = '{1'b1, 1'b0, 32'h0008, 1'b1, 32'h0000, 32'd0, ST_RUN};
        vecs[23] = '{1'b1, 1'b0, 32'h0000, 1'b1, 32'h0000, 32'd0, ST_RUN};

        rst_n     = 1'b0;
        start     = 1'b0;
        stall     = 1'b0;
        next_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset pc", pc_addr, 32'h0);
        check_output("reset count", retired_count, 32'd0);
        check_output("reset status", {29'd0, fault, halted, running}, {29'd0, ST_IDLE});
        check_output("reset cpu_en", {31'd0, cpu_en}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply_stimulus(i);
        end

        // walk up to 0x40, then hit reset together with start
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(1'b0, 1'b0, 32'(i * 4));
        end
        check_output("walk pc", pc_addr, 32'h40);
        check_output("walk count", retired_count, 32'd16);
        rst_n = 1'b0;
        drive_cycle(1'b1, 1'b0, 32'h44);
        check_output("midrst pc", pc_addr, 32'h0);
        check_output("midrst count", retired_count, 32'd0);
        check_output("midrst status", {29'd0, fault, halted, running}, {29'd0, ST_IDLE});
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 32'h8);
        check_output("idle hold pc", pc_addr, 32'h0);
        check_output("idle hold status", {29'd0, fault, halted, running}, {29'd0, ST_IDLE});

`ifdef PC_SEQUENCER_WATCHDOG_EN
        drive_cycle(1'b1, 1'b0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, 1'b0, 32'(i * 4));
        end
        check_output("wd pre status", {29'd0, wd_fault, wd_halted, wd_running}, {29'd0, ST_RUN});
        check_output("wd pre hit", {31'd0, wd_hit}, 32'd0);
        drive_cycle(1'b0, 1'b0, 32'h10);
        check_output("wd pc", wd_pc, 32'h10);
        check_output("wd count", wd_count, 32'd4);
        check_output("wd status", {29'd0, wd_fault, wd_halted, wd_running}, {29'd0, ST_HALT});
        check_output("wd hit", {31'd0, wd_hit}, 32'd1);
        check_output("main no hit", {31'd0, wd_hit_main}, 32'd0);
        drive_cycle(1'b1, 1'b0, 32'h14);
        check_output("wd restart hit", {31'd0, wd_hit}, 32'd0);
        check_output("wd restart pc", wd_pc, 32'h0);
        check_output("wd restart status", {29'd0, wd_fault, wd_halted, wd_running}, {29'd0, ST_RUN});
`endif

        start = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
